// File: rtl/vco_odometer_meas.sv
// Multi-channel ring-oscillator odometer: counts prescaled VCO edges over a programmable
// window of AC_STRESS_CLK cycles and drives a divided copy of the live channel to PAD_OUT.
`timescale 1ns/1ps
module vco_odometer_meas #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DIV_W = 2,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned WIN_W = 16
) (
  input  logic             AC_STRESS_CLK,
  input  logic             RESETB,
  input  logic             EN_VCO,
  input  logic             CLK_KILL,
  input  logic             LOAD,
  input  logic [SEL_W-1:0] CH_SEL,
  input  logic [DIV_W-1:0] VCO_DIV_SEL,
  input  logic [WIN_W-1:0] WIN_LEN,
  input  logic [N_CH-1:0]  VCO_IN,
  output logic [CNT_W-1:0] COUNT,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVF,
  output logic             PAD_OUT
);

  // Largest exponent is 2^DIV_W-1, so the prescaler needs that many bits.
  localparam int unsigned PRE_W = (1 << DIV_W) - 1;

  localparam logic [WIN_W-1:0] WIN_ONE   = WIN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);
  localparam logic [PRE_W:0]   PRE_ONE_X = (PRE_W + 1)'(1);

  typedef enum logic [1:0] {StIdle, StArm, StCount, StDone} state_e;

  state_e           state_q, state_d;
  logic [N_CH-1:0]  sync1_q, sync2_q, hist_q;
  logic [N_CH-1:0]  vco_edge;
  logic             load_q;
  logic [SEL_W-1:0] ch_sh_q, ch_sh_d;
  logic [DIV_W-1:0] div_sh_q, div_sh_d;
  logic [WIN_W-1:0] win_sh_q, win_sh_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [PRE_W-1:0] obs_pre_q, obs_pre_d;
  logic             pad_q, pad_d;
  logic             start_req, abort, meas_edge, obs_edge;

  // Out-of-range selects fall through to channel 0.
  function automatic logic pick_edge(input logic [N_CH-1:0] e, input logic [SEL_W-1:0] sel);
    logic r;
    r = e[0];
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (32'(sel) == i) r = e[i];
    end
    return r;
  endfunction

  // Terminal prescaler value 2^div - 1.
  function automatic logic [PRE_W-1:0] pre_mask(input logic [DIV_W-1:0] div);
    logic [PRE_W:0] one_sh;
    one_sh = PRE_ONE_X << div;
    one_sh = one_sh - PRE_ONE_X;
    return one_sh[PRE_W-1:0];
  endfunction

  assign vco_edge  = sync2_q & ~hist_q;
  assign start_req = LOAD & ~load_q;
  assign abort     = ~EN_VCO | CLK_KILL;
  assign meas_edge = pick_edge(vco_edge, ch_sh_q);
  assign obs_edge  = pick_edge(vco_edge, CH_SEL);

  always_comb begin
    state_d   = state_q;
    ch_sh_d   = ch_sh_q;
    div_sh_d  = div_sh_q;
    win_sh_d  = win_sh_q;
    win_cnt_d = win_cnt_q;
    pre_d     = pre_q;
    count_d   = count_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start_req && !abort) begin
          state_d  = StArm;
          ch_sh_d  = CH_SEL;
          div_sh_d = VCO_DIV_SEL;
          win_sh_d = (WIN_LEN == '0) ? WIN_ONE : WIN_LEN;
          count_d  = '0;
          ovf_d    = 1'b0;
          pre_d    = '0;
        end
      end
      StArm: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          state_d   = StCount;
          win_cnt_d = win_sh_q;
        end
      end
      StCount: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          win_cnt_d = win_cnt_q - WIN_ONE;
          if (win_cnt_q == WIN_ONE) state_d = StDone;
          if (meas_edge) begin
            if (pre_q >= pre_mask(div_sh_q)) begin
              pre_d = '0;
              if (&count_q) ovf_d = 1'b1;
              else          count_d = count_q + CNT_ONE;
            end else begin
              pre_d = pre_q + PRE_ONE;
            end
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Observation path runs off live selects, independent of the measurement FSM.
  always_comb begin
    obs_pre_d = obs_pre_q;
    pad_d     = pad_q;
    if (abort) begin
      obs_pre_d = '0;
      pad_d     = 1'b0;
    end else if (obs_edge) begin
      if (obs_pre_q >= pre_mask(VCO_DIV_SEL)) begin
        obs_pre_d = '0;
        pad_d     = ~pad_q;
      end else begin
        obs_pre_d = obs_pre_q + PRE_ONE;
      end
    end
  end

  always_ff @(posedge AC_STRESS_CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q   <= StIdle;
      sync1_q   <= '0;
      sync2_q   <= '0;
      hist_q    <= '0;
      load_q    <= 1'b0;
      ch_sh_q   <= '0;
      div_sh_q  <= '0;
      win_sh_q  <= '0;
      win_cnt_q <= '0;
      pre_q     <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      obs_pre_q <= '0;
      pad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= VCO_IN;
      sync2_q   <= sync1_q;
      hist_q    <= sync2_q;
      load_q    <= LOAD;
      ch_sh_q   <= ch_sh_d;
      div_sh_q  <= div_sh_d;
      win_sh_q  <= win_sh_d;
      win_cnt_q <= win_cnt_d;
      pre_q     <= pre_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      obs_pre_q <= obs_pre_d;
      pad_q     <= pad_d;
    end
  end

  assign COUNT   = count_q;
  assign BUSY    = (state_q == StArm) || (state_q == StCount);
  assign DONE    = (state_q == StDone);
  assign OVF     = ovf_q;
  assign PAD_OUT = pad_q;

endmodule

// File: tb/tb_vco_odometer_meas.sv
// Directed bench for vco_odometer_meas: window timing, prescale, saturation, abort, observation.
`timescale 1ns/1ps
module tb_vco_odometer_meas;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned DIV_W = 2;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned WIN_W = 16;

  logic             clk, rstb, en_vco, clk_kill, load;
  logic [SEL_W-1:0] ch_sel;
  logic [DIV_W-1:0] div_sel;
  logic [WIN_W-1:0] win_len;
  logic [N_CH-1:0]  vco;
  logic [CNT_W-1:0] count;
  logic             busy, done, ovf, pad_out;

  int checks   = 0;
  int failures = 0;
  int vco_half [N_CH];
  int vco_ph   [N_CH];

  vco_odometer_meas #(
    .N_CH(N_CH), .SEL_W(SEL_W), .DIV_W(DIV_W), .CNT_W(CNT_W), .WIN_W(WIN_W)
  ) dut (
    .AC_STRESS_CLK(clk),
    .RESETB       (rstb),
    .EN_VCO       (en_vco),
    .CLK_KILL     (clk_kill),
    .LOAD         (load),
    .CH_SEL       (ch_sel),
    .VCO_DIV_SEL  (div_sel),
    .WIN_LEN      (win_len),
    .VCO_IN       (vco),
    .COUNT        (count),
    .BUSY         (busy),
    .DONE         (done),
    .OVF          (ovf),
    .PAD_OUT      (pad_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Oscillators toggle on half-ns steps so they never coincide with a clock edge.
  initial begin
    vco = '0;
    for (int c = 0; c < N_CH; c++) vco_ph[c] = 0;
    #0.5;
    forever begin
      #1;
      for (int c = 0; c < N_CH; c++) begin
        if (vco_half[c] == 0) begin
          vco[c] = 1'b0;
          vco_ph[c] = 0;
        end else begin
          vco_ph[c]++;
          if (vco_ph[c] >= vco_half[c]) begin
            vco_ph[c] = 0;
            vco[c] = ~vco[c];
          end
        end
      end
    end
  end

  // k counts negedges after the one on which LOAD is raised.
  task automatic run_window(input int ch, input int div, input int win, input int kill_at,
                            input int reload_at, input int total, output int busy_cnt,
                            output int done_cnt, output int done_at, output int drop_at);
    busy_cnt = 0; done_cnt = 0; done_at = -1; drop_at = -1;
    @(negedge clk);
    ch_sel = SEL_W'(ch); div_sel = DIV_W'(div); win_len = WIN_W'(win); load = 1'b1;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      if (k == 1) load = 1'b0;
      if (busy) busy_cnt++;
      else if (drop_at < 0 && busy_cnt > 0) drop_at = k;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k == kill_at) clk_kill = 1'b1;
      if (k == reload_at) begin
        load = 1'b1; ch_sel = '0; div_sel = 2'd3; win_len = 16'd7;
      end
      if (k == reload_at + 1) load = 1'b0;
    end
  endtask

  task automatic measure_pad_period(output int period);
    int t0;
    logic prev;
    period = -1; t0 = -1; prev = pad_out;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (pad_out && !prev) begin
        if (t0 < 0) t0 = k;
        else begin
          period = k - t0;
          break;
        end
      end
      prev = pad_out;
    end
  endtask

  task automatic test_reset();
    #20;
    checks++; if (count !== 8'd0) begin failures++; $display("FAIL rst_count: got %0d expected 0", count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
    checks++; if (pad_out !== 1'b0) begin failures++; $display("FAIL rst_pad: got %b expected 0", pad_out); end
    @(negedge clk); rstb = 1'b1;
    // Start a window and reset it from the middle of COUNT.
    @(negedge clk); ch_sel = 3'd1; div_sel = 2'd0; win_len = 16'd100; load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy: got %b expected 1", busy); end
    #2 rstb = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if (count !== 8'd0) begin failures++; $display("FAIL rst_mid_count: got %0d expected 0", count); end
    checks++; if (pad_out !== 1'b0) begin failures++; $display("FAIL rst_mid_pad: got %b expected 0", pad_out); end
    #100;
    @(negedge clk); rstb = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    int b, d, da, dr;
    run_window(1, 0, 100, -1, -1, 110, b, d, da, dr);
    checks++; if (b !== 101) begin failures++; $display("FAIL basic_busy: got %0d expected 101", b); end
    checks++; if (d !== 1) begin failures++; $display("FAIL basic_done_cnt: got %0d expected 1", d); end
    checks++; if (da !== 102) begin failures++; $display("FAIL basic_done_at: got %0d expected 102", da); end
    checks++; if (!(count >= 9 && count <= 11)) begin failures++; $display("FAIL basic_count: got %0d expected 9..11", count); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL basic_ovf: got %b expected 0", ovf); end
  endtask

  task automatic test_prescale();
    int b, d, da, dr;
    run_window(2, 2, 1000, -1, -1, 1010, b, d, da, dr);
    checks++; if (!(count >= 61 && count <= 63)) begin failures++; $display("FAIL pre_div2_count: got %0d expected 61..63", count); end
    checks++; if (da !== 1002) begin failures++; $display("FAIL pre_div2_done_at: got %0d expected 1002", da); end
    run_window(2, 3, 1000, -1, -1, 1010, b, d, da, dr);
    checks++; if (!(count >= 30 && count <= 32)) begin failures++; $display("FAIL pre_div3_count: got %0d expected 30..32", count); end
  endtask

  task automatic test_saturation();
    int b, d, da, dr;
    run_window(0, 0, 2000, -1, -1, 2010, b, d, da, dr);
    checks++; if (count !== 8'd255) begin failures++; $display("FAIL sat_count: got %0d expected 255", count); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL sat_ovf: got %b expected 1", ovf); end
  endtask

  task automatic test_zero_window();
    int b, d, da, dr;
    run_window(0, 0, 0, -1, -1, 10, b, d, da, dr);
    checks++; if (b !== 2) begin failures++; $display("FAIL zero_busy: got %0d expected 2", b); end
    checks++; if (da !== 3) begin failures++; $display("FAIL zero_done_at: got %0d expected 3", da); end
    checks++; if (d !== 1) begin failures++; $display("FAIL zero_done_cnt: got %0d expected 1", d); end
    checks++; if (count > 8'd1) begin failures++; $display("FAIL zero_count: got %0d expected 0..1", count); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL zero_ovf_clear: got %b expected 0", ovf); end
  endtask

  task automatic test_abort();
    int b, d, da, dr;
    run_window(1, 0, 100, 50, -1, 60, b, d, da, dr);
    checks++; if (dr !== 51) begin failures++; $display("FAIL abort_drop_at: got %0d expected 51", dr); end
    checks++; if (!(count >= 4 && count <= 6)) begin failures++; $display("FAIL abort_count: got %0d expected 4..6", count); end
    repeat (150) begin
      @(negedge clk);
      if (done) d++;
    end
    checks++; if (d !== 0) begin failures++; $display("FAIL abort_no_done: got %0d pulses expected 0", d); end
    checks++; if (!(count >= 4 && count <= 6)) begin failures++; $display("FAIL abort_frozen: got %0d expected 4..6", count); end
    clk_kill = 1'b0;
    // With EN_VCO low a LOAD edge must not start anything.
    en_vco = 1'b0;
    run_window(1, 0, 20, -1, -1, 30, b, d, da, dr);
    checks++; if (b !== 0) begin failures++; $display("FAIL en_gate_busy: got %0d expected 0", b); end
    en_vco = 1'b1;
  endtask

  task automatic test_back_to_back();
    int b, d, da, dr;
    // Re-pulsed LOAD plus live select changes mid-window must be ignored.
    run_window(1, 0, 100, -1, 30, 120, b, d, da, dr);
    checks++; if (b !== 101) begin failures++; $display("FAIL reload_busy: got %0d expected 101", b); end
    checks++; if (d !== 1) begin failures++; $display("FAIL reload_done_cnt: got %0d expected 1", d); end
    checks++; if (da !== 102) begin failures++; $display("FAIL reload_done_at: got %0d expected 102", da); end
    checks++; if (!(count >= 9 && count <= 11)) begin failures++; $display("FAIL reload_count: got %0d expected 9..11", count); end
  endtask

  task automatic test_observation();
    int p;
    int seen;
    @(negedge clk); ch_sel = 3'd3; div_sel = 2'd1; vco_half[3] = 40;
    measure_pad_period(p);
    checks++; if (p !== 32) begin failures++; $display("FAIL obs_period: got %0d expected 32", p); end
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (pad_out) begin
        seen = 1;
        break;
      end
    end
    checks++; if (seen !== 1) begin failures++; $display("FAIL obs_pad_high: got %0d expected 1", seen); end
    clk_kill = 1'b1;
    @(negedge clk);
    checks++; if (pad_out !== 1'b0) begin failures++; $display("FAIL obs_kill: got %b expected 0", pad_out); end
    clk_kill = 1'b0;
    ch_sel = 3'd5;
    vco_half[0] = 40; vco_half[1] = 0; vco_half[2] = 0; vco_half[3] = 0;
    measure_pad_period(p);
    checks++; if (p !== 32) begin failures++; $display("FAIL obs_sel_oob: got %0d expected 32", p); end
  endtask

  initial begin
    vco_half[0] = 20; vco_half[1] = 50; vco_half[2] = 20; vco_half[3] = 40;
    rstb = 1'b0; en_vco = 1'b1; clk_kill = 1'b0; load = 1'b0;
    ch_sel = '0; div_sel = '0; win_len = '0;
    test_reset();
    test_basic();
    test_prescale();
    test_saturation();
    test_zero_window();
    test_abort();
    test_back_to_back();
    test_observation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vco_odometer_meas.md
Name: vco_odometer_meas

Overview:
- Parametrised multi-channel successor to the single-VCO stress/readout path.
- Takes N_CH raw ring-oscillator outputs that are asynchronous to the stress clock.
- Synchronises the selected channel and prescales it by a programmable power of two.
- Counts prescaled edges over a programmable window of AC_STRESS_CLK cycles and reports the beat count with done/overflow status.
- Also drives a free-running divided copy of the selected channel to PAD_OUT for bench observation.

Parameters:
- N_CH, 4, number of VCO input channels (≥1)
- SEL_W, 2, channel-select width (≥ clog2(N_CH), min 1)
- DIV_W, 2, prescale-select width; prescale ratio = 2^VCO_DIV_SEL
- CNT_W, 16, result counter width
- WIN_W, 16, window-length width

Ports:
- AC_STRESS_CLK  in  1  reference/stress clock; all state on its rising edge
- RESETB  in  1  reset: asynchronous assert, active-low
- EN_VCO  in  1  measurement/observation enable
- CLK_KILL  in  1  high = abort measurement, force PAD_OUT low
- LOAD  in  1  start request; a rising edge starts a measurement
- CH_SEL  in  SEL_W  channel select; values ≥ N_CH select channel 0
- VCO_DIV_SEL  in  DIV_W  prescale exponent
- WIN_LEN  in  WIN_W  window length in clock cycles; 0 is treated as 1
- VCO_IN  in  N_CH  raw oscillator outputs, asynchronous
- COUNT  out  CNT_W  prescaled edge count of last or aborted measurement
- BUSY  out  1  measurement in progress
- DONE  out  1  one-cycle pulse when a window completes normally
- OVF  out  1  COUNT saturated during the current or last measurement
- PAD_OUT  out  1  observation toggle of the selected channel

Behaviour:
- Reset (RESETB=0, async): all flops cleared; COUNT=0, BUSY=0, DONE=0, OVF=0, PAD_OUT=0; FSM in IDLE.
- Sync: per channel, a 2-flop synchroniser plus a history flop. Rising edge = sync2 & ~hist.
  - VCO high and low phases must each be ≥2 clock periods; faster inputs are out of spec, and undercounting is allowed.
- LOAD edge detect: LOAD_q registered; start_req = LOAD & ~LOAD_q.
- FSM states: IDLE, ARM, COUNT, DONE.
  - IDLE → ARM when start_req & EN_VCO & ~CLK_KILL. On that edge:
    - shadow-latch CH_SEL, VCO_DIV_SEL, and WIN_LEN (0→1);
    - clear COUNT, OVF, and the measurement prescaler.
  - ARM → COUNT after 1 cycle. The window counter is loaded with the shadow WIN_LEN.
  - COUNT, each cycle:
    - window counter decrements;
    - an edge on the shadow channel increments the prescaler;
    - when the prescaler equals 2^div−1 and an edge occurs, the prescaler wraps to 0 and COUNT increments;
    - COUNT saturates at all-ones and sets OVF (sticky until the next start);
    - when the window counter reaches 0, → DONE.
    - The COUNT state lasts exactly WIN_LEN cycles.
  - DONE: DONE=1 for exactly one cycle, → IDLE.
- BUSY = 1 in ARM and COUNT. Relative to the sampling edge of start_req, BUSY rises 1 cycle later and DONE is asserted WIN_LEN+2 cycles after that edge.
- Abort: EN_VCO=0 or CLK_KILL=1 sampled in ARM or COUNT → IDLE next cycle.
  - No DONE pulse is issued.
  - COUNT and OVF hold their partial values.
- start_req while BUSY or in DONE: ignored and not queued. A fresh LOAD rising edge is required.
- COUNT/OVF hold from DONE or abort until the next accepted start.
- Live CH_SEL, VCO_DIV_SEL, and WIN_LEN changes during BUSY do not affect the measurement.
- Observation path: independent of the FSM, using live CH_SEL and VCO_DIV_SEL.
  - A separate prescaler counts edges on the live channel.
  - PAD_OUT toggles on each prescaler wrap.
  - When EN_VCO=0 or CLK_KILL=1, the prescaler clears and PAD_OUT=0 on the next cycle.
- All arithmetic is unsigned. Prescaler width = 2^DIV_W − 1 bits max exponent, sized to hold 2^(2^DIV_W −1)−1.

Test Plan:
1. Reset
   - Stimulus: RESETB low for 100 ns at arbitrary times, including mid-COUNT.
   - Required: all outputs 0 immediately (async); FSM IDLE; subsequent LOAD edge measures normally.
2. Basic window
   - Stimulus: ch1 period 10 clk, DIV_SEL=0, WIN_LEN=100, LOAD rise.
   - Required: BUSY high 101 cycles; DONE single pulse at start+102; COUNT=10±1; OVF=0.
3. Prescale
   - Stimulus: ch2 period 4 clk, DIV_SEL=2, WIN_LEN=1000.
   - Required: COUNT=62±1. Repeat with DIV_SEL=3 → 31±1.
4. Saturation and zero window
   - Stimulus: CNT_W=8 build, ch0 period 4 clk, DIV_SEL=0, WIN_LEN=2000.
     - Required: COUNT=255, OVF=1.
   - Stimulus: WIN_LEN=0.
     - Required: BUSY 2 cycles; DONE at start+3; COUNT ≤1.
5. Abort and ignored LOAD
   - Stimulus: CLK_KILL=1 at cycle 50 of a 100-cycle window.
     - Required: BUSY low next cycle; no DONE; COUNT frozen at partial value.
   - Stimulus: LOAD re-pulsed during BUSY.
     - Required: no restart.
6. Observation
   - Stimulus: ch3 period 8 clk, DIV_SEL=1, EN_VCO=1.
     - Required: PAD_OUT period 32 clk.
   - Stimulus: CLK_KILL=1.
     - Required: PAD_OUT=0 within 1 cycle.
   - Stimulus: CH_SEL=5 with N_CH=4.
     - Required: channel 0 is observed.
